// File: rtl/hidden_mac.sv
// Time-multiplexed hidden layer: NUM_PCTN neurons share one signed fixed-point MAC.
// Weights/biases load through wr; start evaluates i_k and o_valid pulses with the full layer.
module hidden_mac #(
    parameter int NUM_INPUT = 2,
    parameter int NUM_PCTN  = 3,
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int ACT       = 0,
    parameter int GUARD     = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr,
    input  logic [NUM_PCTN*NUM_INPUT*WIDTH-1:0] i_w,
    input  logic [NUM_PCTN*WIDTH-1:0]           i_b,
    input  logic                                start,
    input  logic [NUM_INPUT*WIDTH-1:0]          i_k,
    output logic                                busy,
    output logic                                o_valid,
    output logic [NUM_PCTN*WIDTH-1:0]           o_a,
    output logic [NUM_PCTN*NUM_INPUT*WIDTH-1:0] o_w,
    output logic [NUM_PCTN*WIDTH-1:0]           o_b
);

    localparam int AW = WIDTH + GUARD;
    localparam int PW = (2 * WIDTH > AW) ? 2 * WIDTH : AW;
    localparam int NW = (NUM_PCTN > 1) ? $clog2(NUM_PCTN) : 1;
    localparam int JW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;

    localparam logic signed [AW-1:0]  SAT_MAX = AW'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [AW-1:0]  SAT_MIN = ~SAT_MAX;
    localparam logic signed [WIDTH:0] ONE     = (WIDTH+1)'(1) << FRAC;
    localparam logic signed [WIDTH:0] HALF    = ONE >>> 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ACT
    } state_t;

    state_t                                state_q, state_d;
    logic [NUM_PCTN*NUM_INPUT*WIDTH-1:0]   w_q, w_d;
    logic [NUM_PCTN*WIDTH-1:0]             b_q, b_d;
    logic [NUM_INPUT*WIDTH-1:0]            k_q, k_d;
    logic [NUM_PCTN*WIDTH-1:0]             shadow_q, shadow_d;
    logic [NUM_PCTN*WIDTH-1:0]             oa_q, oa_d;
    logic signed [AW-1:0]                  acc_q, acc_d;
    logic [NW-1:0]                         n_q, n_d;
    logic [JW-1:0]                         j_q, j_d;
    logic                                  valid_q, valid_d;

    logic signed [WIDTH-1:0] k_sel, w_sel, x_sat, y_act;
    logic signed [PW-1:0]    prod, prod_sh;
    logic signed [WIDTH:0]   hs;
    logic [NW-1:0]           n_nx;

    // Shared datapath: product term, saturation and activation of the current accumulator.
    always_comb begin
        k_sel   = k_q[int'(j_q)*WIDTH +: WIDTH];
        w_sel   = w_q[(int'(n_q)*NUM_INPUT + int'(j_q))*WIDTH +: WIDTH];
        prod    = PW'(k_sel) * PW'(w_sel);
        prod_sh = prod >>> FRAC;

        if (acc_q > SAT_MAX)      x_sat = SAT_MAX[WIDTH-1:0];
        else if (acc_q < SAT_MIN) x_sat = SAT_MIN[WIDTH-1:0];
        else                      x_sat = acc_q[WIDTH-1:0];

        // One extra bit keeps x/4 + 0.5 from overflowing before the clamp.
        hs    = ($signed({x_sat[WIDTH-1], x_sat}) >>> 2) + HALF;
        y_act = x_sat;
        if (ACT == 1) begin
            if (x_sat[WIDTH-1]) y_act = '0;
        end else if (ACT == 2) begin
            if (hs[WIDTH])      y_act = '0;
            else if (hs > ONE)  y_act = ONE[WIDTH-1:0];
            else                y_act = hs[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        b_d      = b_q;
        k_d      = k_q;
        shadow_d = shadow_q;
        oa_d     = oa_q;
        acc_d    = acc_q;
        n_d      = n_q;
        j_d      = j_q;
        valid_d  = 1'b0;
        n_nx     = n_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (wr) begin
                    w_d = i_w;
                    b_d = i_b;
                end else if (start) begin
                    k_d     = i_k;
                    n_d     = '0;
                    j_d     = '0;
                    acc_d   = AW'($signed(b_q[0 +: WIDTH]));
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + $signed(prod_sh[AW-1:0]);
                if (j_q == JW'(NUM_INPUT - 1)) begin
                    j_d     = '0;
                    state_d = S_ACT;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_ACT: begin
                shadow_d[int'(n_q)*WIDTH +: WIDTH] = y_act;
                if (n_q == NW'(NUM_PCTN - 1)) begin
                    oa_d    = shadow_d;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    n_d     = n_nx;
                    j_d     = '0;
                    acc_d   = AW'($signed(b_q[int'(n_nx)*WIDTH +: WIDTH]));
                    state_d = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            w_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            shadow_q <= '0;
            oa_q     <= '0;
            acc_q    <= '0;
            n_q      <= '0;
            j_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            b_q      <= b_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            oa_q     <= oa_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            j_q      <= j_d;
            valid_q  <= valid_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign o_valid = valid_q;
    assign o_a     = oa_q;
    assign o_w     = w_q;
    assign o_b     = b_q;

endmodule
